qlearn_action_gen: RTL and testbench
====================================

Name: qlearn_action_gen

Overview:
- Upstream feeder of the Q-learning update pipeline; owns the agent's position on the 8x8 grid.
- Each step it chooses an action epsilon-greedily, using a 16-bit LFSR and a greedy-action lookup.
- It computes the wall-clipped next state and offers {s, action, nexts} to the update pipeline over a valid/ready handshake.
- It tracks step and episode counts and restarts the episode on goal or step limit.

Parameters:
- START_STATE, 6'b100_001, state loaded at reset and at every episode restart ({x[2:0], y[2:0]}).
- GOAL_STATE, 6'b111_111, terminal state.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
- MAX_STEPS, 8'd255, step limit per episode (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  run enable.
- i_eps  in  8  explore threshold; explore when lfsr[7:0] < i_eps.
- o_greedy_addr  out  6  state address to the greedy-action table.
- i_greedy_action  in  2  table read data; 1-cycle read latency.
- o_valid  out  1  step offer valid.
- i_ready  in  1  pipeline accepts the offer.
- o_s  out  6  current state.
- o_action  out  2  chosen action: 00 left, 01 up, 10 right, 11 down.
- o_nexts  out  6  next state.
- o_sa_addr  out  8  {o_s, o_action}, the Q/R table address.
- o_explore  out  1  1 = random action, 0 = greedy action.
- o_step_cnt  out  8  steps taken in the current episode.
- o_episode_cnt  out  16  completed episodes; wraps at 16'hFFFF->0.
- o_episode_done  out  1  one-cycle pulse on episode end.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; cur_s = START_STATE; lfsr = seed.
  - o_valid, o_action, o_nexts, o_explore, o_step_cnt, o_episode_cnt, o_episode_done = 0.
  - o_s = START_STATE; o_sa_addr = {START_STATE, 2'b00}.
- o_greedy_addr = cur_s, combinational, in all states.
- FSM:
  - IDLE: if i_en, go to LOOKUP.
  - LOOKUP: one cycle; the table reads o_greedy_addr; go to DECIDE.
  - DECIDE: register the step into the output registers, then go to OFFER with o_valid = 1.
    - explore = (lfsr[7:0] < i_eps).
    - action = explore ? lfsr[9:8] : i_greedy_action.
    - nexts computed from cur_s and action (rules below).
  - OFFER: outputs are held stable while o_valid && !i_ready. On o_valid && i_ready:
    - o_valid <= 0; lfsr advances once; cur_s <= nexts; o_step_cnt += 1.
    - If nexts == GOAL_STATE or o_step_cnt == MAX_STEPS-1, go to RESTART.
    - Else, go to LOOKUP if i_en, otherwise IDLE.
  - RESTART: one cycle.
    - o_episode_done = 1; cur_s <= START_STATE; o_step_cnt <= 0; o_episode_cnt += 1.
    - Then go to LOOKUP if i_en, otherwise IDLE.
- Next state, with x = cur_s[5:3] and y = cur_s[2:0]:
  - left: y-1; up: x-1; right: y+1; down: x+1.
  - A move that would leave 0..7 keeps nexts = cur_s (wall); there is no wrap-around.
- LFSR: Fibonacci x^16+x^14+x^13+x^11+1; shifts only on handshake, never while stalled.
- Deasserting i_en during LOOKUP, DECIDE or OFFER does not abort: the pending offer is completed, then the FSM goes to IDLE.
- Min step period is 3 cycles (LOOKUP, DECIDE, handshake in OFFER); a goal step adds the RESTART cycle.
- i_eps is sampled only in DECIDE. i_eps = 0 means never explore; i_eps = 255 means explore unless lfsr[7:0] = 255.
- Reset mid-offer drops o_valid immediately; no partial step is counted.

Test Plan:
- Reset, i_en=1, i_eps=0, i_greedy_action=2'b10, i_ready=1:
  - First o_valid at the 3rd clk after release, with o_s=100_001, o_action=10, o_nexts=100_010, o_sa_addr=8'h86, o_explore=0.
- Wall: force cur_s=000_000 via START_STATE=0, greedy action 00 and then 01:
  - o_nexts=000_000 both times.
  - o_step_cnt increments each step.
- Backpressure: hold i_ready=0 for 10 cycles in OFFER:
  - o_s, o_action, o_nexts stay stable.
  - lfsr is unchanged.
  - Exactly one step is counted when i_ready rises.
- Goal: START_STATE=111_110, greedy action 10:
  - o_nexts=111_111.
  - Next cycle o_episode_done=1 for 1 cycle and o_episode_cnt=1.
  - The following offer has o_s=111_110 and o_step_cnt=0.
- Exploration: i_eps=8'hFF, LFSR_SEED=16'hACE1:
  - First o_explore=1 and o_action=lfsr[9:8]=2'b00.
  - The sequence over 20 steps matches the reference LFSR model.
- Step limit: MAX_STEPS=4, greedy action 00 from 100_000:
  - After the 4th handshake, RESTART occurs with o_episode_done pulsed.
  - o_step_cnt returns to 0.

Source files
------------

// File: rtl/qlearn_action_gen_if.sv
// Step-offer channel from the action generator to the Q-learning update pipeline.
// The generator drives the step fields and valid; the pipeline returns ready.
interface qlearn_action_gen_if;
  logic       o_valid;
  logic       i_ready;
  logic [5:0] o_s;
  logic [1:0] o_action;
  logic [5:0] o_nexts;
  logic [7:0] o_sa_addr;
  logic       o_explore;

  modport master (
    output o_valid, o_s, o_action, o_nexts, o_sa_addr, o_explore,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_s, o_action, o_nexts, o_sa_addr, o_explore,
    output i_ready
  );
endinterface

// File: rtl/qlearn_action_gen.sv
// Epsilon-greedy action generator for an 8x8 grid Q-learning agent: owns the agent
// position, picks an action per step and offers {s, action, nexts} downstream.
module qlearn_action_gen #(
  parameter logic [5:0]  START_STATE = 6'b100_001,
  parameter logic [5:0]  GOAL_STATE  = 6'b111_111,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [7:0]  MAX_STEPS   = 8'd255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_en,
  input  logic [7:0]                 i_eps,
  output logic [5:0]                 o_greedy_addr,
  input  logic [1:0]                 i_greedy_action,
  qlearn_action_gen_if.master        offer,
  output logic [7:0]                 o_step_cnt,
  output logic [15:0]                o_episode_cnt,
  output logic                       o_episode_done
);

  // An all-zero seed would lock the LFSR up forever.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, OFFER, RESTART} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cur_s;
  logic [15:0] lfsr;
  logic [2:0]  cx, cy;
  logic        explore_d;
  logic [1:0]  action_d;
  logic [5:0]  nexts_d;
  logic        hs;
  logic        episode_end;

  assign cx            = cur_s[5:3];
  assign cy            = cur_s[2:0];
  assign o_greedy_addr = cur_s;
  assign offer.o_sa_addr = {offer.o_s, offer.o_action};
  assign hs          = (state == OFFER) && offer.o_valid && offer.i_ready;
  assign episode_end = (offer.o_nexts == GOAL_STATE) || (o_step_cnt == MAX_STEPS - 8'd1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    explore_d = (lfsr[7:0] < i_eps);
    action_d  = explore_d ? lfsr[9:8] : i_greedy_action;
    nexts_d   = cur_s;
    case (action_d)
      2'b00: if (cy != 3'd0) nexts_d = {cx, cy - 3'd1};
      2'b01: if (cx != 3'd0) nexts_d = {cx - 3'd1, cy};
      2'b10: if (cy != 3'd7) nexts_d = {cx, cy + 3'd1};
      2'b11: if (cx != 3'd7) nexts_d = {cx + 3'd1, cy};
      default: nexts_d = cur_s;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = DECIDE;
      DECIDE:  state_nxt = OFFER;
      OFFER:   if (hs) state_nxt = episode_end ? RESTART : (i_en ? LOOKUP : IDLE);
      RESTART: state_nxt = i_en ? LOOKUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_s           <= START_STATE;
      lfsr            <= SEED;
      offer.o_valid   <= 1'b0;
      offer.o_s       <= START_STATE;
      offer.o_action  <= 2'b00;
      offer.o_nexts   <= 6'd0;
      offer.o_explore <= 1'b0;
      o_step_cnt      <= 8'd0;
      o_episode_cnt   <= 16'd0;
      o_episode_done  <= 1'b0;
    end else begin
      o_episode_done <= 1'b0;
      case (state)
        DECIDE: begin
          offer.o_valid   <= 1'b1;
          offer.o_s       <= cur_s;
          offer.o_action  <= action_d;
          offer.o_nexts   <= nexts_d;
          offer.o_explore <= explore_d;
        end
        OFFER: if (hs) begin
          // The LFSR only moves on an accepted step, so stalls never perturb the sequence.
          offer.o_valid <= 1'b0;
          lfsr          <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
          cur_s         <= offer.o_nexts;
          o_step_cnt    <= o_step_cnt + 8'd1;
        end
        RESTART: begin
          o_episode_done <= 1'b1;
          cur_s          <= START_STATE;
          o_step_cnt     <= 8'd0;
          o_episode_cnt  <= o_episode_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qlearn_action_gen.sv
// Self-checking bench for qlearn_action_gen: directed phases plus randomized steps,
// each offer compared against a transaction-level grid/LFSR model.
module tb_qlearn_action_gen;

  localparam logic [5:0] GOAL = 6'b111_111;

  logic       clk;
  logic       rst_n;
  logic [2:0] en;
  logic [7:0] eps;
  logic       ready;
  logic [1:0] gtab [64];

  qlearn_action_gen_if ifa();
  qlearn_action_gen_if ifb();
  qlearn_action_gen_if ifc();

  logic [5:0]  ga_a, ga_b, ga_c;
  logic [1:0]  gq_a, gq_b, gq_c;
  logic [7:0]  sc_a, sc_b, sc_c;
  logic [15:0] ep_a, ep_b, ep_c;
  logic        dn_a, dn_b, dn_c;

  assign ifa.i_ready = ready;
  assign ifb.i_ready = ready;
  assign ifc.i_ready = ready;

  qlearn_action_gen u_a (
    .clk(clk), .rst_n(rst_n), .i_en(en[0]), .i_eps(eps),
    .o_greedy_addr(ga_a), .i_greedy_action(gq_a), .offer(ifa),
    .o_step_cnt(sc_a), .o_episode_cnt(ep_a), .o_episode_done(dn_a)
  );

  qlearn_action_gen #(.START_STATE(6'b111_110), .MAX_STEPS(8'd4)) u_b (
    .clk(clk), .rst_n(rst_n), .i_en(en[1]), .i_eps(eps),
    .o_greedy_addr(ga_b), .i_greedy_action(gq_b), .offer(ifb),
    .o_step_cnt(sc_b), .o_episode_cnt(ep_b), .o_episode_done(dn_b)
  );

  qlearn_action_gen #(.START_STATE(6'b000_000)) u_c (
    .clk(clk), .rst_n(rst_n), .i_en(en[2]), .i_eps(eps),
    .o_greedy_addr(ga_c), .i_greedy_action(gq_c), .offer(ifc),
    .o_step_cnt(sc_c), .o_episode_cnt(ep_c), .o_episode_done(dn_c)
  );

  // Greedy-action table with one cycle of read latency.
  always @(posedge clk) begin
    gq_a <= gtab[ga_a];
    gq_b <= gtab[ga_b];
    gq_c <= gtab[ga_c];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          sel;
  logic        mv, mex, mdone;
  logic [5:0]  ms, mn, mga;
  logic [1:0]  ma;
  logic [7:0]  msa, mstep;
  logic [15:0] mep;

  always_comb begin
    case (sel)
      1: begin
        mv = ifb.o_valid; ms = ifb.o_s; ma = ifb.o_action; mn = ifb.o_nexts; msa = ifb.o_sa_addr;
        mex = ifb.o_explore; mstep = sc_b; mep = ep_b; mdone = dn_b; mga = ga_b;
      end
      2: begin
        mv = ifc.o_valid; ms = ifc.o_s; ma = ifc.o_action; mn = ifc.o_nexts; msa = ifc.o_sa_addr;
        mex = ifc.o_explore; mstep = sc_c; mep = ep_c; mdone = dn_c; mga = ga_c;
      end
      default: begin
        mv = ifa.o_valid; ms = ifa.o_s; ma = ifa.o_action; mn = ifa.o_nexts; msa = ifa.o_sa_addr;
        mex = ifa.o_explore; mstep = sc_a; mep = ep_a; mdone = dn_a; mga = ga_a;
      end
    endcase
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: agent position, LFSR value and counters, advanced per accepted step.
  logic [5:0]  m_s;
  logic [15:0] m_lfsr;
  int          m_step, m_ep;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    int unsigned v, fb;
    v  = 32'(l);
    fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 32'd1;
    return 16'((v >> 1) | (fb << 15));
  endfunction

  function automatic logic [5:0] ref_next(input logic [5:0] s, input logic [1:0] a);
    int x, y, nx, ny;
    x = int'(s) / 8; y = int'(s) % 8; nx = x; ny = y;
    case (a)
      2'd0: ny = y - 1;
      2'd1: nx = x - 1;
      2'd2: ny = y + 1;
      default: nx = x + 1;
    endcase
    if (nx < 0 || nx > 7 || ny < 0 || ny > 7) return s;
    return 6'(nx * 8 + ny);
  endfunction

  function automatic logic [5:0] start_of(input int which);
    case (which)
      1: return 6'b111_110;
      2: return 6'b000_000;
      default: return 6'b100_001;
    endcase
  endfunction

  function automatic int max_of(input int which);
    return (which == 1) ? 4 : 255;
  endfunction

  task automatic do_reset(input int which);
    en = 3'b000; ready = 1'b0; rst_n = 1'b0; sel = which;
    repeat (2) @(negedge clk);
    m_s = start_of(which); m_lfsr = 16'hACE1; m_step = 0; m_ep = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (mv !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("offer_seen", 32'(mv), 32'd1);
  endtask

  // One full step: check the offer, optionally stall, handshake, then check the aftermath.
  task automatic run_step(input int stall, input bit drop_en, input bit upd,
                          input logic [5:0] ua, input logic [1:0] uv, input logic [7:0] neps);
    bit         expl, restart;
    logic [1:0] act;
    logic [5:0] nx;
    int         pulses;
    logic [15:0] ep_seen;
    wait_valid();
    if (mv !== 1'b1) return;
    expl = (m_lfsr[7:0] < eps);
    act  = expl ? m_lfsr[9:8] : gtab[m_s];
    nx   = ref_next(m_s, act);
    check("s", 32'(ms), 32'(m_s));
    check("action", 32'(ma), 32'(act));
    check("nexts", 32'(mn), 32'(nx));
    check("sa_addr", 32'(msa), 32'({m_s, act}));
    check("explore", 32'(mex), 32'(expl));
    check("step_cnt", 32'(mstep), 32'(m_step));
    check("episode_cnt", 32'(mep), 32'(16'(m_ep)));
    check("greedy_addr", 32'(mga), 32'(m_s));
    if (upd) gtab[ua] = uv;
    if (drop_en) en[sel] = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(mv), 32'd1);
      check("stall_s", 32'(ms), 32'(m_s));
      check("stall_action", 32'(ma), 32'(act));
      check("stall_nexts", 32'(mn), 32'(nx));
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    eps   = neps;
    check("hs_valid_drop", 32'(mv), 32'd0);
    check("hs_step_cnt", 32'(mstep), 32'(8'(m_step + 1)));
    restart = (nx == GOAL) || (m_step == max_of(sel) - 1);
    m_lfsr  = lfsr_adv(m_lfsr);
    m_s     = nx;
    m_step++;
    pulses  = 0;
    ep_seen = 16'd0;
    for (int i = 0; i < 3; i++) begin
      if (mdone === 1'b1) begin
        pulses++;
        ep_seen = mep;
      end
      if (i < 2) @(negedge clk);
    end
    check("done_pulses", 32'(pulses), restart ? 32'd1 : 32'd0);
    if (restart) begin
      m_ep++;
      m_s    = start_of(sel);
      m_step = 0;
      check("done_episode_cnt", 32'(ep_seen), 32'(16'(m_ep)));
    end
    if (drop_en) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("idle_no_valid", 32'(mv), 32'd0);
      end
      en[sel] = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) gtab[i] = 2'b10;
    eps = 8'd0; ready = 1'b0; en = 3'b000; sel = 0; rst_n = 1'b0;

    // Reset state and first-offer latency.
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(mv), 32'd0);
    check("rst_s", 32'(ms), 32'h21);
    check("rst_sa_addr", 32'(msa), 32'h84);
    check("rst_action", 32'(ma), 32'd0);
    check("rst_nexts", 32'(mn), 32'd0);
    check("rst_explore", 32'(mex), 32'd0);
    check("rst_step_cnt", 32'(mstep), 32'd0);
    check("rst_episode_cnt", 32'(mep), 32'd0);
    check("rst_done", 32'(mdone), 32'd0);
    check("rst_greedy_addr", 32'(mga), 32'h21);
    m_s = 6'b100_001; m_lfsr = 16'hACE1; m_step = 0; m_ep = 0;
    rst_n = 1'b1;
    en[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("first_valid_timing", 32'(mv), (i == 3) ? 32'd1 : 32'd0);
    end
    check("tp_first_s", 32'(ms), 32'h21);
    check("tp_first_action", 32'(ma), 32'd2);
    check("tp_first_nexts", 32'(mn), 32'h22);
    check("tp_first_sa_addr", 32'(msa), 32'h86);
    check("tp_first_explore", 32'(mex), 32'd0);
    run_step(0, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);
    run_step(10, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);
    for (int i = 0; i < 6; i++) run_step(i % 2, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);

    // Reset in the middle of an offer.
    wait_valid();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(mv), 32'd0);
    check("rst_mid_step_cnt", 32'(mstep), 32'd0);
    check("rst_mid_s", 32'(ms), 32'h21);

    // Full exploration from the reset seed.
    do_reset(0);
    eps   = 8'hFF;
    en[0] = 1'b1;
    wait_valid();
    check("tp_explore_flag", 32'(mex), 32'd1);
    check("tp_explore_action", 32'(ma), 32'd0);
    for (int i = 0; i < 20; i++) run_step(0, 1'b0, 1'b0, 6'd0, 2'd0, 8'hFF);

    // Randomized greedy table, epsilon, backpressure and enable drops.
    do_reset(0);
    for (int i = 0; i < 64; i++) gtab[i] = 2'($urandom_range(0, 3));
    eps   = 8'($urandom_range(0, 255));
    en[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [7:0] ne;
      r  = int'($urandom_range(0, 3));
      ne = (r == 0) ? 8'd0 : (r == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      run_step(($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), 1'b0, 6'd0, 2'd0, ne);
    end

    // Wall at x=7, step limit of 4, then a goal step.
    do_reset(1);
    eps = 8'd0;
    gtab[6'b111_110] = 2'b11;
    en[1] = 1'b1;
    for (int i = 0; i < 3; i++) run_step(0, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);
    run_step(1, 1'b0, 1'b1, 6'b111_110, 2'b10, 8'd0);
    wait_valid();
    check("tp_goal_nexts", 32'(mn), 32'h3F);
    run_step(0, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);
    wait_valid();
    check("tp_after_goal_s", 32'(ms), 32'h3E);
    check("tp_after_goal_step_cnt", 32'(mstep), 32'd0);
    check("tp_after_goal_episode_cnt", 32'(mep), 32'd2);
    run_step(0, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);

    // Walls at the origin: left then up.
    do_reset(2);
    eps = 8'd0;
    gtab[0] = 2'b00;
    en[2] = 1'b1;
    run_step(0, 1'b0, 1'b1, 6'd0, 2'b01, 8'd0);
    wait_valid();
    check("tp_wall_up_nexts", 32'(mn), 32'd0);
    check("tp_wall_up_step_cnt", 32'(mstep), 32'd1);
    run_step(2, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
